ddr2_line_fetch: RTL
====================

# ddr2_line_fetch

Per-line prefetch engine between the DDR2 controller's local read port and the video timing / pixel output stage. On each line-start strobe from the timing generator it requests one line from DDR2 and pulls exactly H_ACTIVE 24-bit words into a small prefetch FIFO. It then pops the FIFO one pixel per data-enable cycle. Underrun, overflow and late-line conditions are flagged sticky per frame.

## Interface
- H_ACTIVE, 800: pixels (24-bit words) fetched per line; range 2..4095.
- V_ACTIVE, 600: lines requested per frame; range 1..4095.
- FIFO_DEPTH, 16: prefetch FIFO depth; power of two, minimum 8.
- clk  in  1  pixel/host clock, same clock as the controller's host side. One clock only.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at start of frame (vertical sync).
- line_start  in  1  one-cycle pulse ahead of each active line's DE region.
- pix_de  in  1  active-video data enable from the timing generator.
- pix_data  out  24  pixel to the video output, registered.
- local_rd_req  out  1  one-cycle line read request to the controller.
- local_rd_ready  out  1  pull strobe to the controller read FIFO.
- local_rd_data  in  24  read word from the controller.
- local_rd_valid  in  1  qualifies local_rd_data in the same cycle.
- err_underrun  out  1  sticky: pix_de seen with FIFO empty.
- err_overflow  out  1  sticky: valid word arrived with FIFO full; the word is dropped.
- err_late  out  1  sticky: line_start arrived while the previous line was still fetching.

## Operation
- States: IDLE, REQ, FETCH.
- IDLE -> REQ on line_start when line_cnt < V_ACTIVE.
- REQ lasts one cycle, drives local_rd_req=1, clears issue_cnt and rcv_cnt, increments line_cnt, then goes to FETCH.
- In FETCH, local_rd_ready = (issue_cnt < H_ACTIVE) && (fifo_level <= FIFO_DEPTH-3). issue_cnt increments on each ready cycle.
- Controller contract, binding on both sides: each ready cycle yields exactly one valid word within 1 or 2 cycles. The 3-entry headroom covers this latency.
- Any local_rd_valid writes local_rd_data into the FIFO. This applies in every state, so late words after ready deasserts are still captured. If the FIFO is full, the word is dropped and err_overflow is set.
- rcv_cnt counts accepted valid words. FETCH -> IDLE in the cycle rcv_cnt reaches H_ACTIVE, i.e. the cycle the last word is written.
- line_start in REQ or FETCH: the request is ignored and err_late is set. The fetch continues unchanged.
- line_start when line_cnt == V_ACTIVE: ignored, no flag.
- frame_start, any state:
  - FIFO is flushed (pointers zeroed), state -> IDLE, line_cnt=0.
  - All three err_* flags are cleared.
  - pix_data is not altered.
- frame_start and line_start in the same cycle: frame_start action applies. The next cycle is REQ for line 0 and err_late is not set.
- Output path, evaluated every cycle:
  - pix_de && !empty: pop the FIFO and register the head into pix_data.
  - pix_de && empty: pix_data <= 24'h000000 and err_underrun is set.
  - !pix_de: pix_data holds.
- Simultaneous FIFO push and pop is legal at any level, including full (level unchanged) and empty with push: the pop sees empty, so the underrun rule applies and the pushed word stays.
- Widths:
  - issue_cnt and rcv_cnt: clog2(H_ACTIVE+1).
  - line_cnt: clog2(V_ACTIVE+1).
  - fifo_level: clog2(FIFO_DEPTH)+1.
  - FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: pix_data=0, local_rd_req=0, local_rd_ready=0, all err_*=0, state IDLE, FIFO empty, all counters 0.
- Reset mid-fetch aborts immediately. The FIFO is emptied and any further valid words are accepted normally after rst_n deasserts.
- line_start at cycle t: local_rd_req=1 at t+1 and local_rd_ready is first eligible at t+2.
- Pixel latency: pix_de at cycle t gives pix_data valid from t+1.
- local_rd_req is never high for two consecutive cycles.
- Count of local_rd_ready high cycles per line is exactly H_ACTIVE.
- local_rd_ready is 0 in IDLE and REQ.
- err_* flags assert one cycle after the triggering event and remain set until frame_start or reset.

## Test plan
- Basic line (H_ACTIVE=8, V_ACTIVE=2, DEPTH=16), valid latency 1, data 1..8:
  - local_rd_req pulse at t+1.
  - Exactly 8 ready cycles, then IDLE.
  - 8 pix_de cycles -> pix_data = 1..8 in order.
  - No error flags.
- Backpressure: H_ACTIVE=20, DEPTH=8, no pix_de, latency 2 -> ready drops when level reaches 6. fifo_level never exceeds 8 and err_overflow stays 0. Draining via pix_de resumes ready until 20 are issued.
- Underrun: pix_de for 10 cycles with only 8 words fetched -> last 2 pix_data = 0 and err_underrun=1. frame_start clears the flag.
- Frame boundary: V_ACTIVE=2, three line_start pulses -> only 2 local_rd_req. frame_start coincident with line_start -> flush, then local_rd_req next cycle, line_cnt=1.
- Late line: line_start while rcv_cnt=3 of 8 -> no new local_rd_req, err_late=1, the current line completes with 8 words.
- Async reset mid-FETCH (rcv_cnt=4) -> all outputs 0 immediately. After release, line_start produces a clean 8-word fetch.

Source files
------------

// File: rtl/ddr2_line_fetch.sv
// Per-line DDR2 prefetch: requests one line per line_start, fills a small FIFO
// from the controller read port and pops one pixel per data-enable cycle.
//
// state | meaning
// IDLE  | waiting for line_start (and line budget left in this frame)
// REQ   | one-cycle line request to the controller, counters restart
// FETCH | pulling H_ACTIVE words, throttled by FIFO headroom
module ddr2_line_fetch #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic        pix_de,
   output logic [23:0] pix_data,
   output logic        local_rd_req,
   output logic        local_rd_ready,
   input  logic [23:0] local_rd_data,
   input  logic        local_rd_valid,
   output logic        err_underrun,
   output logic        err_overflow,
   output logic        err_late
);

   localparam int CW = $clog2(H_ACTIVE + 1);
   localparam int LW = $clog2(V_ACTIVE + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FW = PW + 1;

   localparam logic [CW-1:0] H_CNT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
   localparam logic [LW-1:0] V_CNT  = LW'(V_ACTIVE);
   localparam logic [FW-1:0] F_FULL = FW'(FIFO_DEPTH);
   localparam logic [FW-1:0] F_HEAD = FW'(FIFO_DEPTH - 3);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FETCH = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] issue_cnt;
   logic [CW-1:0] rcv_cnt;
   logic [LW-1:0] line_cnt;
   logic [FW-1:0] fifo_level;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [23:0]   mem [FIFO_DEPTH];

   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push;
   logic drop;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == F_FULL);

   // frame_start flushes, so nothing moves through the FIFO in that cycle.
   // A full FIFO still accepts a word when the same cycle pops one.
   assign pop  = pix_de && !fifo_empty && !frame_start;
   assign push = local_rd_valid && (!fifo_full || pop) && !frame_start;
   assign drop = local_rd_valid && fifo_full && !pop && !frame_start;

   // Decoded from registered state so it reacts to the level in the same
   // cycle; the 3-entry headroom absorbs the controller's 1-2 cycle latency.
   assign local_rd_ready = (state == FETCH) && (issue_cnt < H_CNT) &&
                           (fifo_level <= F_HEAD);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= local_rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         issue_cnt    <= '0;
         rcv_cnt      <= '0;
         line_cnt     <= '0;
         fifo_level   <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         pix_data     <= '0;
         local_rd_req <= 1'b0;
         err_underrun <= 1'b0;
         err_overflow <= 1'b0;
         err_late     <= 1'b0;
      end else begin
         local_rd_req <= 1'b0;
         if (frame_start) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            line_cnt     <= '0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
            err_late     <= 1'b0;
            if (line_start) begin
               state        <= REQ;
               local_rd_req <= 1'b1;
            end else begin
               state <= IDLE;
            end
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (!push && pop) fifo_level <= fifo_level - 1'b1;

            if (pop) begin
               pix_data <= mem[rd_ptr];
            end else if (pix_de) begin
               pix_data     <= '0;
               err_underrun <= 1'b1;
            end

            if (drop) err_overflow <= 1'b1;
            if (line_start && state != IDLE) err_late <= 1'b1;

            case (state)
               IDLE: begin
                  if (line_start && line_cnt < V_CNT) begin
                     state        <= REQ;
                     local_rd_req <= 1'b1;
                  end
               end
               REQ: begin
                  issue_cnt <= '0;
                  rcv_cnt   <= '0;
                  line_cnt  <= line_cnt + 1'b1;
                  state     <= FETCH;
               end
               FETCH: begin
                  if (local_rd_ready) issue_cnt <= issue_cnt + 1'b1;
                  if (push) begin
                     rcv_cnt <= rcv_cnt + 1'b1;
                     if (rcv_cnt == H_LAST) state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
